// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle for alu_share_arbiter.
// master = requesters plus the shared ALU; slave = the arbiter.
interface alu_share_arbiter_if #(
   parameter int unsigned DATA_LENGTH = 32
);
   logic                   Req0Valid, Req1Valid;
   logic                   Req0Ready, Req1Ready;
   logic [DATA_LENGTH-1:0] Req0A, Req0B, Req1A, Req1B;
   logic [3:0]             Req0Op, Req1Op;
   logic [DATA_LENGTH-1:0] AluA, AluB;
   logic [3:0]             AluOp;
   logic [DATA_LENGTH-1:0] AluResult;
   logic [1:0]             AluComp;
   logic                   Rsp0Valid, Rsp1Valid;
   logic                   Rsp0Ready, Rsp1Ready;
   logic [DATA_LENGTH-1:0] RspResult;
   logic [1:0]             RspComp;
   logic                   Busy;

   modport master (
      output Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Op, Req1Op,
      output AluResult, AluComp, Rsp0Ready, Rsp1Ready,
      input  Req0Ready, Req1Ready, AluA, AluB, AluOp,
      input  Rsp0Valid, Rsp1Valid, RspResult, RspComp, Busy
   );

   modport slave (
      input  Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Op, Req1Op,
      input  AluResult, AluComp, Rsp0Ready, Rsp1Ready,
      output Req0Ready, Req1Ready, AluA, AluB, AluOp,
      output Rsp0Valid, Rsp1Valid, RspResult, RspComp, Busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Optional grant counters enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
   parameter int unsigned DATA_LENGTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   alu_share_arbiter_if.slave        bus
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]               Grant0Count,
   output logic [15:0]               Grant1Count
`endif
);
   localparam int unsigned OP_W = 4;
   localparam logic [OP_W-1:0] OP_NOP = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t                 r_state;
   logic                   r_ptr;
   logic                   r_owner;
   logic [DATA_LENGTH-1:0] r_a, r_b;
   logic [OP_W-1:0]        r_alu_op;
   logic [DATA_LENGTH-1:0] r_rsp_result;
   logic [1:0]             r_rsp_comp;
   logic                   r_rsp0_valid, r_rsp1_valid;
   logic                   r_busy;

   logic w_idle, w_gnt0, w_gnt1, w_rsp_done;

   // Ready is combinational from the current Valids; suppressed during reset
   assign w_idle     = (r_state == S_IDLE) && !rst;
   assign w_gnt0     = w_idle && bus.Req0Valid && (!bus.Req1Valid || !r_ptr);
   assign w_gnt1     = w_idle && bus.Req1Valid && (!bus.Req0Valid ||  r_ptr);
   assign w_rsp_done = (r_rsp0_valid && bus.Rsp0Ready) || (r_rsp1_valid && bus.Rsp1Ready);

   assign bus.Req0Ready = w_gnt0;
   assign bus.Req1Ready = w_gnt1;
   assign bus.AluA      = r_a;
   assign bus.AluB      = r_b;
   assign bus.AluOp     = r_alu_op;
   assign bus.Rsp0Valid = r_rsp0_valid;
   assign bus.Rsp1Valid = r_rsp1_valid;
   assign bus.RspResult = r_rsp_result;
   assign bus.RspComp   = r_rsp_comp;
   assign bus.Busy      = r_busy;

   // AluOp carries the captured op only for the single EXEC cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ptr        <= 1'b0;
         r_owner      <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_alu_op     <= OP_NOP;
         r_rsp_result <= '0;
         r_rsp_comp   <= 2'd0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_a      <= w_gnt1 ? bus.Req1A  : bus.Req0A;
                  r_b      <= w_gnt1 ? bus.Req1B  : bus.Req0B;
                  r_alu_op <= w_gnt1 ? bus.Req1Op : bus.Req0Op;
                  r_owner  <= w_gnt1;
                  r_ptr    <= !w_gnt1;
                  r_busy   <= 1'b1;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_result <= bus.AluResult;
               r_rsp_comp   <= bus.AluComp;
               r_alu_op     <= OP_NOP;
               r_rsp0_valid <= !r_owner;
               r_rsp1_valid <= r_owner;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (w_rsp_done) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] r_grant0_count, r_grant1_count;

   // Saturating per-requester accept counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant0_count <= 16'd0;
         r_grant1_count <= 16'd0;
      end else begin
         if (w_gnt0 && (r_grant0_count != 16'hFFFF)) r_grant0_count <= r_grant0_count + 16'd1;
         if (w_gnt1 && (r_grant1_count != 16'hFFFF)) r_grant1_count <= r_grant1_count + 16'd1;
      end
   end

   assign Grant0Count = r_grant0_count;
   assign Grant1Count = r_grant1_count;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized plus directed bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.DATA_LENGTH(DW)) ifc();

`ifdef ALU_ARB_STATS_EN
   logic [15:0] g0c, g1c;
`endif

   alu_share_arbiter #(.DATA_LENGTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
`ifdef ALU_ARB_STATS_EN
      ,
      .Grant0Count (g0c),
      .Grant1Count (g1c)
`endif
   );

   function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [3:0] op);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         4'd7: return a * b;
         4'd8: return (b == '0) ? '1 : a / b;
         default: return '0;
      endcase
   endfunction

   function automatic logic [1:0] cmp_f(logic [DW-1:0] a, logic [DW-1:0] b);
      if ($signed(a) == $signed(b)) return 2'd0;
      if ($signed(a) <  $signed(b)) return 2'd1;
      return 2'd2;
   endfunction

   // Stand-in for the shared ALU
   assign ifc.AluResult = alu_f(ifc.AluA, ifc.AluB, ifc.AluOp);
   assign ifc.AluComp   = cmp_f(ifc.AluA, ifc.AluB);

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Transaction model: phase 0 waiting, 1 operation computing, 2 result offered
   int            m_phase = 0;
   bit            m_owner = 1'b0;
   bit            m_ptr   = 1'b0;
   logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
   logic [3:0]    m_op = 4'd15;
   logic [1:0]    m_comp = 2'd0;
   int            m_cnt0 = 0, m_cnt1 = 0;
   bit            last_g0, last_g1;
   int            gq[$];

   // One clock: check outputs at negedge, advance the model, return just after posedge
   task automatic step();
      bit g0, g1;
      @(negedge clk);
      g0 = !rst && m_phase == 0 && ifc.Req0Valid && (!ifc.Req1Valid || !m_ptr);
      g1 = !rst && m_phase == 0 && ifc.Req1Valid && (!ifc.Req0Valid ||  m_ptr);
      chk("req0_ready", ifc.Req0Ready, g0);
      chk("req1_ready", ifc.Req1Ready, g1);
      chk("alu_op",     ifc.AluOp, (m_phase == 1) ? m_op : 4'd15);
      chk("alu_a",      ifc.AluA, m_a);
      chk("alu_b",      ifc.AluB, m_b);
      chk("rsp0_valid", ifc.Rsp0Valid, m_phase == 2 && !m_owner);
      chk("rsp1_valid", ifc.Rsp1Valid, m_phase == 2 &&  m_owner);
      chk("rsp_result", ifc.RspResult, m_res);
      chk("rsp_comp",   ifc.RspComp, m_comp);
      chk("busy",       ifc.Busy, m_phase != 0);
`ifdef ALU_ARB_STATS_EN
      chk("grant0_count", g0c, m_cnt0);
      chk("grant1_count", g1c, m_cnt1);
`endif
      last_g0 = g0;
      last_g1 = g1;
      if (rst) begin
         m_phase = 0; m_ptr = 1'b0; m_owner = 1'b0;
         m_a = '0; m_b = '0; m_res = '0; m_comp = 2'd0; m_op = 4'd15;
         m_cnt0 = 0; m_cnt1 = 0;
      end else if (g0 || g1) begin
         m_a     = g1 ? ifc.Req1A  : ifc.Req0A;
         m_b     = g1 ? ifc.Req1B  : ifc.Req0B;
         m_op    = g1 ? ifc.Req1Op : ifc.Req0Op;
         m_owner = g1;
         m_ptr   = !g1;
         m_phase = 1;
         gq.push_back(int'(g1));
         if (g1) begin if (m_cnt1 < 65535) m_cnt1++; end
         else    begin if (m_cnt0 < 65535) m_cnt0++; end
      end else if (m_phase == 1) begin
         m_res   = alu_f(m_a, m_b, m_op);
         m_comp  = cmp_f(m_a, m_b);
         m_phase = 2;
      end else if (m_phase == 2 && (m_owner ? ifc.Rsp1Ready : ifc.Rsp0Ready)) begin
         m_phase = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_req0();
      ifc.Req0A  = $urandom;
      ifc.Req0B  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      ifc.Req0Op = 4'($urandom_range(0, 15));
   endtask

   task automatic rand_req1();
      ifc.Req1A  = $urandom;
      ifc.Req1B  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      ifc.Req1Op = 4'($urandom_range(0, 15));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      ifc.Req0Valid = 1'b0; ifc.Req1Valid = 1'b0;
      ifc.Req0A = '0; ifc.Req0B = '0; ifc.Req0Op = 4'd15;
      ifc.Req1A = '0; ifc.Req1B = '0; ifc.Req1Op = 4'd15;
      ifc.Rsp0Ready = 1'b0; ifc.Rsp1Ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      step();

      // Single ADD from requester 0
      ifc.Req0A = 32'd7; ifc.Req0B = 32'd5; ifc.Req0Op = 4'd0;
      ifc.Req0Valid = 1'b1; ifc.Rsp0Ready = 1'b1;
      #1 chk("add_req0_ready", ifc.Req0Ready, 1'b1);
      step();
      ifc.Req0Valid = 1'b0;
      chk("add_alu_op", ifc.AluOp, 4'd0);
      step();
      chk("add_rsp0_valid", ifc.Rsp0Valid, 1'b1);
      chk("add_result", ifc.RspResult, 32'd12);
      chk("add_comp", ifc.RspComp, 2'd2);
      step();
      chk("add_idle", ifc.Busy, 1'b0);
      step();

      // Both requesters continuously valid: grants alternate
      do_reset();
      gq.delete();
      rand_req0(); rand_req1();
      ifc.Req0Valid = 1'b1; ifc.Req1Valid = 1'b1;
      ifc.Rsp0Ready = 1'b1; ifc.Rsp1Ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (last_g0) rand_req0();
         if (last_g1) rand_req1();
      end
      chk("rr_grant_count", gq.size(), 4);
      for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_grant_order", gq[i], i % 2);
      ifc.Req0Valid = 1'b0; ifc.Req1Valid = 1'b0;
      repeat (3) step();

      // SUB on requester 1 with stalled response; requester 0 waits
      do_reset();
      ifc.Req1A = 32'd3; ifc.Req1B = 32'd9; ifc.Req1Op = 4'd1;
      ifc.Req1Valid = 1'b1; ifc.Rsp1Ready = 1'b0;
      ifc.Req0A = 32'd100; ifc.Req0B = 32'd4; ifc.Req0Op = 4'd8; ifc.Rsp0Ready = 1'b0;
      step();
      ifc.Req1Valid = 1'b0; ifc.Req0Valid = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp1_valid", ifc.Rsp1Valid, 1'b1);
         chk("stall_result", ifc.RspResult, 32'hFFFF_FFFA);
         chk("stall_comp", ifc.RspComp, 2'd1);
         step();
      end
      ifc.Rsp1Ready = 1'b1;
      step();
      chk("after_hs_req0_ready", ifc.Req0Ready, 1'b1);
      step();
      ifc.Req0Valid = 1'b0; ifc.Rsp0Ready = 1'b1;
      repeat (3) step();

      // Reset during RESP aborts the operation
      ifc.Req0A = 32'h55; ifc.Req0B = 32'h0F; ifc.Req0Op = 4'd2;
      ifc.Req0Valid = 1'b1; ifc.Rsp0Ready = 1'b0;
      step();
      ifc.Req0Valid = 1'b0;
      step();
      chk("abort_in_resp", ifc.Rsp0Valid, 1'b1);
      do_reset();
      chk("abort_rsp0_valid", ifc.Rsp0Valid, 1'b0);
      chk("abort_busy", ifc.Busy, 1'b0);
      chk("abort_alu_op", ifc.AluOp, 4'd15);
      ifc.Rsp0Ready = 1'b1;
      repeat (3) step();

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 79) == 0);
         if (!(ifc.Req0Valid && !last_g0)) begin
            ifc.Req0Valid = $urandom_range(0, 1) != 0;
            rand_req0();
         end
         if (!(ifc.Req1Valid && !last_g1)) begin
            ifc.Req1Valid = $urandom_range(0, 1) != 0;
            rand_req1();
         end
         ifc.Rsp0Ready = $urandom_range(0, 2) != 0;
         ifc.Rsp1Ready = $urandom_range(0, 2) != 0;
         step();
      end
      rst = 1'b0;
      ifc.Req0Valid = 1'b0; ifc.Req1Valid = 1'b0;
      ifc.Rsp0Ready = 1'b1; ifc.Rsp1Ready = 1'b1;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have one parameter: DATA_LENGTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- Req0Valid, Req1Valid  input  1  requester i presents an operation
- Req0Ready, Req1Ready  output  1  requester i operation accepted this cycle
- Req0A, Req0B, Req1A, Req1B  input  DATA_LENGTH  operands
- Req0Op, Req1Op  input  4  ALU operation code (0 ADD … 8 DIV, 15 NOP)
- AluA, AluB  output  DATA_LENGTH  operands to shared ALU
- AluOp  output  4  operation to shared ALU
- AluResult  input  DATA_LENGTH  ALU result, combinational from AluA/AluB/AluOp
- AluComp  input  2  ALU compare flag (0 EQ, 1 LT, 2 GT)
- Rsp0Valid, Rsp1Valid  output  1  response for requester i available
- Rsp0Ready, Rsp1Ready  input  1  requester i consumes response
- RspResult  output  DATA_LENGTH  shared response result
- RspComp  output  2  shared response compare flag
- Busy  output  1  an operation is in flight (state != IDLE)

Function
REQ-003 The FSM SHALL have three states: IDLE, EXEC, RESP; one operation in flight at most.
REQ-004 In IDLE, ReqiReady SHALL be asserted combinationally for exactly the granted requester; at most one ReqiReady high per cycle; both low outside IDLE.
REQ-005 Grant SHALL be: only one Valid -> that requester; both Valid -> requester indicated by round-robin pointer Ptr; neither -> no grant.
REQ-006 On handshake (ReqiValid & ReqiReady) the block SHALL capture ReqiA, ReqiB, ReqiOp and owner id, set Ptr to the other requester, and go to EXEC next cycle.
REQ-007 In EXEC (exactly one cycle) AluA/AluB/AluOp SHALL carry the captured values; at that cycle's edge AluResult/AluComp SHALL be registered into RspResult/RspComp and the state SHALL go to RESP.
REQ-008 Outside EXEC AluOp SHALL be 4'd15; AluA/AluB SHALL hold the last captured operands.
REQ-009 In RESP, RspiValid SHALL be high only for the owner; RspResult/RspComp SHALL be stable until handshake.
REQ-010 On RspiValid & RspiReady the block SHALL return to IDLE; the next request is accepted no earlier than the following cycle (minimum 3 cycles per operation; accept-to-RspValid latency 2 cycles).
REQ-011 Rsp Ready of the non-owner SHALL be ignored; Req Valid asserted in EXEC/RESP SHALL wait without loss (requester holds it).
REQ-012 Opcode values 9–14 SHALL be passed to the ALU unchanged (ALU returns 0); DIV by zero result is whatever the ALU returns, not trapped.

Reset
REQ-013 While rst is high at a clock edge: state IDLE, Ptr = 0, captured operands = 0, RspResult = 0, RspComp = 0, all Valid/Ready outputs = 0, Busy = 0, AluOp = 4'd15.
REQ-014 Reset asserted in EXEC or RESP SHALL abort the operation; no response is issued for it.

Configuration
REQ-015 With macro ALU_ARB_STATS_EN defined, the block SHALL add outputs Grant0Count and Grant1Count (16-bit, reset 0, increment on each accept of that requester, saturate at 16'hFFFF); without it these ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-016 Req0 only, A=7, B=5, Op=0, Rsp0Ready=1 -> Req0Ready cycle 0, AluOp=0 cycle 1, Rsp0Valid cycle 2 with RspResult=12, RspComp=2.
REQ-017 Req0 and Req1 held valid continuously after reset -> grants alternate 0,1,0,1; each Rsp valid only for its owner.
REQ-018 Req1 Op=1, A=3, B=9, Rsp1Ready low 5 cycles -> Rsp1Valid held, RspResult=-6, RspComp=1 stable; Req0 not accepted until cycle after Rsp1 handshake.
REQ-019 rst pulsed during RESP -> next cycle all Valid low, Busy=0, AluOp=15; no response for aborted op.
REQ-020 With ALU_ARB_STATS_EN, 3 Req0 and 2 Req1 accepts -> Grant0Count=3, Grant1Count=2; cleared by rst.
